// File: rtl/ibex_mem_responder_if.sv
// Ibex-style req/gnt/rvalid memory bus between an initiator and a memory responder.
// Signal suffixes are written from the responder's point of view.
interface ibex_mem_responder_if;
    logic        stall_i;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    // Memory side: accepts requests, returns responses.
    modport slave (
        input  stall_i, req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );

    // Core side: issues requests, consumes responses.
    modport master (
        output stall_i, req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/ibex_mem_responder.sv
// Memory-side responder for the Ibex req/gnt/rvalid handshake.
// Grants requests against a word-addressed SRAM and returns in-order responses
// after a fixed latency, with address-range error injection.
module ibex_mem_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] AddrBase       = 32'h0000_0000,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2,
    parameter logic [31:0] ErrAddrLo      = 32'hFFFF_FFFF,
    parameter logic [31:0] ErrAddrHi      = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ibex_mem_responder_if.slave   bus
);

    localparam int unsigned IdxW    = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
    localparam logic [32:0] AddrLo  = {1'b0, AddrBase};
    localparam logic [32:0] AddrEnd = {1'b0, AddrBase} + 33'(4 * MemWords);

    // Reject configurations the response pipeline and counter cannot support.
    if (RespLatency < 1 || RespLatency > 8) begin : g_bad_latency
        $error("ibex_mem_responder: RespLatency must be in 1..8");
    end
    if (MaxOutstanding < 1 || MaxOutstanding > 8) begin : g_bad_outstanding
        $error("ibex_mem_responder: MaxOutstanding must be in 1..8");
    end
    if ((AddrBase % 4) != 0) begin : g_bad_base
        $error("ibex_mem_responder: AddrBase must be 4-byte aligned");
    end
    if (MemWords < 1 || AddrEnd > 33'h1_0000_0000) begin : g_bad_size
        $error("ibex_mem_responder: MemWords must be >= 1 and fit in the address space");
    end

    logic [31:0]           mem [MemWords];
    logic [CntW-1:0]       outstanding;
    logic [RespLatency-1:0] pipe_valid;
    logic [RespLatency-1:0] pipe_err;
    logic [31:0]           pipe_data [RespLatency];

    logic                  in_range;
    logic                  in_window;
    logic                  req_err;
    logic                  gnt;
    logic                  rvalid;
    logic [IdxW-1:0]       idx;
    logic [31:0]           rd_word;

    // Address decode, error classification and grant decision for the current request.
    // NOTE: every signal gets a value on every path through this block, so no latches
    // are inferred; blocking '=' is correct here because this is combinational logic.
    always_comb begin
        in_range  = ({1'b0, bus.addr_i} >= AddrLo) && ({1'b0, bus.addr_i} < AddrEnd);
        in_window = (bus.addr_i >= ErrAddrLo) && (bus.addr_i <= ErrAddrHi);
        req_err   = !in_range || in_window;
        idx       = IdxW'((bus.addr_i - AddrBase) >> 2);
        rd_word   = '0;
        if (!req_err) begin
            rd_word = mem[idx];
        end
        gnt = bus.req_i && !bus.stall_i && !rst_i &&
              (outstanding < CntW'(MaxOutstanding));
    end

    assign rvalid       = pipe_valid[RespLatency-1];
    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rvalid;
    assign bus.err_o    = pipe_err[RespLatency-1];
    assign bus.rdata_o  = pipe_data[RespLatency-1];

    // Byte-enabled write into the backing store, committed in the grant cycle.
    // NOTE: the storage array is intentionally left out of reset; contents survive rst_i
    // and a reset of a RAM array would prevent it from mapping onto real SRAM.
    always_ff @(posedge clk_i) begin
        if (gnt && bus.we_i && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.be_i[b]) begin
                    mem[idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response shift register: stage 0 captures the granted request, the last stage drives the outputs.
    // NOTE: sequential state is updated with non-blocking '<=' so every stage shifts
    // from its pre-edge value regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int s = 0; s < int'(RespLatency); s++) begin
                pipe_data[s] <= '0;
            end
        end else begin
            pipe_valid[0] <= gnt;
            pipe_err[0]   <= gnt && req_err;
            pipe_data[0]  <= (gnt && !bus.we_i && !req_err) ? rd_word : 32'h0;
            for (int s = 1; s < int'(RespLatency); s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_err[s]   <= pipe_err[s-1];
                pipe_data[s]  <= pipe_data[s-1];
            end
        end
    end

    // Granted-but-unanswered request count; a grant and a response in one cycle cancel out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding <= '0;
        end else begin
            case ({gnt, rvalid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule
